// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the add/sub/multiply datapath: start/busy handshake,
// single-cycle add/sub, W-cycle shift-add multiply, registered result with done/err pulses.
module alu_seq_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic [2*W-1:0]   f,
    output logic             done,
    output logic             err
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        MUL
    } state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [1:0]      op_reg;
    logic [2*W-1:0]  acc;
    logic [CW-1:0]   cnt;

    logic [2*W-1:0]  a_ext;
    logic [2*W-1:0]  b_ext;
    logic [2*W-1:0]  partial;
    logic [2*W-1:0]  acc_next;

    always_comb begin
        a_ext    = {{W{1'b0}}, a_reg};
        b_ext    = {{W{1'b0}}, b_reg};
        partial  = b_reg[cnt] ? (a_ext << cnt) : '0;
        acc_next = acc + partial;
    end

    // The final partial product is folded into f on the same edge that ends MUL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            f      <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            2'b01, 2'b10: begin
                                a_reg  <= a;
                                b_reg  <= b;
                                op_reg <= op;
                                state  <= EXEC;
                                busy   <= 1'b1;
                            end
                            2'b11: begin
                                a_reg  <= a;
                                b_reg  <= b;
                                op_reg <= op;
                                acc    <= '0;
                                cnt    <= '0;
                                state  <= MUL;
                                busy   <= 1'b1;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                EXEC: begin
                    f     <= (op_reg == 2'b10) ? (a_ext - b_ext) : (a_ext + b_ext);
                    done  <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        f     <= acc_next;
                        done  <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
